int_to_single_arbiter: RTL

INT_TO_SINGLE_ARBITER -- requirements
Module: int_to_single_arbiter

---
 rtl/int_to_single_arbiter.sv | 58 +++++
 1 files changed

// File: rtl/int_to_single_arbiter.sv
// int_to_single_arbiter: round-robin sharing of one int-to-float converter among four requesters
module int_to_single_arbiter #(
  parameter int LATENCY = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in_data,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  input  logic [3:0]   req_en,
  output logic [31:0]  conv_a,
  input  logic [31:0]  conv_z,
  output logic [31:0]  out_data,
  output logic [3:0]   out_valid,
  output logic         busy
);
  logic [1:0]             last_grant;
  logic [1:0]             gid;
  logic [3:0]             cand;
  logic                   hs;
  // One extra tag stage covers the cycle between the conv_a register and the
  // converter's LATENCY cycles, so the result is sampled LATENCY+1 edges after issue.
  logic [LATENCY:0]       tv;
  logic [LATENCY:0][1:0]  tid;
  assign cand = in_valid & req_en;
  assign hs   = |in_ready;
  assign busy = |tv;
  // Grant the first eligible requester after last_grant; the lowest k wins, so iterate downward.
  always_comb begin
    in_ready = '0;
    gid = last_grant;
    for (int k = 4; k >= 1; k--)
      if (rst_n && cand[2'(last_grant + 2'(k))]) begin
        gid = 2'(last_grant + 2'(k));
        in_ready = 4'b1 << gid;
      end
  end
  // Issue operands, track owners through the converter, and register the returning result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 2'd3;
      conv_a <= '0;
      tv <= '0;
      tid <= '0;
      out_data <= '0;
      out_valid <= '0;
    end else begin
      tv <= {tv[LATENCY-1:0], hs};
      tid <= {tid[LATENCY-1:0], gid};
      if (hs) begin
        last_grant <= gid;
        conv_a <= in_data[32*gid +: 32];
      end
      out_valid <= tv[LATENCY] ? 4'b1 << tid[LATENCY] : 4'b0;
      if (tv[LATENCY]) out_data <= conv_z;
    end
  end
endmodule
